// File: rtl/fetch_ifid.sv
// Instruction fetch stage with IF/ID pipeline register, one-entry skid buffer
// for stalls, and branch redirect that lets an outstanding memory request drain.
module fetch_ifid (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic        o_ifid_valid,
  output logic [31:0] o_ifid_instr,
  output logic [31:0] o_ifid_pc4,
  output logic [5:0]  o_opcode
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      r_state;
  logic        r_req;
  logic [31:0] r_pc;
  logic [31:0] r_target;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc4;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;

  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  assign w_target   = {i_branch_target[31:2], 2'b00};
  assign w_pc_plus4 = r_pc + 32'd4;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_req       <= 1'b0;
      r_pc        <= '0;
      r_target    <= '0;
      r_buf_instr <= '0;
      r_buf_pc4   <= '0;
      r_valid     <= 1'b0;
      r_instr     <= '0;
      r_pc4       <= '0;
    end else begin
      // A redirect kills the IF/ID contents and any buffered word in every state.
      if (i_branch_taken) begin
        r_valid     <= 1'b0;
        r_instr     <= '0;
        r_buf_instr <= '0;
        r_buf_pc4   <= '0;
      end

      unique case (r_state)
        S_IDLE: begin
          if (i_branch_taken) begin
            r_pc <= w_target;
          end
          r_state <= S_FETCH;
          r_req   <= 1'b1;
        end

        S_FETCH: begin
          if (i_branch_taken) begin
            if (i_imem_ack) begin
              r_pc <= w_target;
            end else begin
              // Request still in flight: keep its address, redirect once it returns.
              r_target <= w_target;
              r_state  <= S_DROP;
            end
          end else if (i_imem_ack) begin
            r_pc <= w_pc_plus4;
            if (i_stall) begin
              r_buf_instr <= i_imem_data;
              r_buf_pc4   <= w_pc_plus4;
              r_state     <= S_HOLD;
              r_req       <= 1'b0;
            end else begin
              r_instr <= i_imem_data;
              r_pc4   <= w_pc_plus4;
              r_valid <= 1'b1;
            end
          end else if (!i_stall) begin
            r_valid <= 1'b0;
          end
        end

        S_HOLD: begin
          if (i_branch_taken) begin
            r_pc    <= w_target;
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end else if (!i_stall) begin
            r_instr <= r_buf_instr;
            r_pc4   <= r_buf_pc4;
            r_valid <= 1'b1;
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end
        end

        S_DROP: begin
          if (i_imem_ack) begin
            r_pc    <= i_branch_taken ? w_target : r_target;
            r_state <= S_FETCH;
          end else if (i_branch_taken) begin
            r_target <= w_target;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign o_imem_req   = r_req;
  assign o_imem_addr  = r_pc;
  assign o_ifid_valid = r_valid;
  assign o_ifid_instr = r_instr;
  assign o_ifid_pc4   = r_pc4;
  assign o_opcode     = r_instr[31:26];

endmodule

// File: tb/tb_fetch_ifid.sv
// Scoreboard bench for fetch_ifid: each step drives inputs for one clock and
// queues the outputs expected after that edge.
module tb_fetch_ifid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] br_tgt = '0;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [5:0]  opcode;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb[$];

  fetch_ifid dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .o_imem_req      (imem_req),
    .o_imem_addr     (imem_addr),
    .i_imem_ack      (imem_ack),
    .i_imem_data     (imem_data),
    .i_stall         (stall),
    .i_branch_taken  (br),
    .i_branch_target (br_tgt),
    .o_ifid_valid    (ifid_valid),
    .o_ifid_instr    (ifid_instr),
    .o_ifid_pc4      (ifid_pc4),
    .o_opcode        (opcode)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8) return 32'h8C01_0004;
    return a + 32'h20;
  endfunction

  task automatic step(input string tag, input logic ack, input logic stl,
                      input logic b, input logic [31:0] tgt,
                      input logic e_req, input logic [31:0] e_addr,
                      input logic e_valid, input logic [31:0] e_instr,
                      input logic [31:0] e_pc4);
    exp_t e;
    exp_t got;
    imem_ack  = ack;
    imem_data = ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    stall     = stl;
    br        = b;
    br_tgt    = tgt;
    e.tag = tag; e.req = e_req; e.addr = e_addr;
    e.valid = e_valid; e.instr = e_instr; e.pc4 = e_pc4;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({got.tag, ".req"},   {31'd0, imem_req},   {31'd0, got.req});
    chk({got.tag, ".addr"},  imem_addr,           got.addr);
    chk({got.tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, got.valid});
    chk({got.tag, ".instr"}, ifid_instr,          got.instr);
    chk({got.tag, ".pc4"},   ifid_pc4,            got.pc4);
    chk({got.tag, ".op"},    {26'd0, opcode},     {26'd0, got.instr[31:26]});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".req"},   {31'd0, imem_req},   32'd0);
    chk({tag, ".addr"},  imem_addr,           32'd0);
    chk({tag, ".valid"}, {31'd0, ifid_valid}, 32'd0);
    chk({tag, ".instr"}, ifid_instr,          32'd0);
    chk({tag, ".pc4"},   ifid_pc4,            32'd0);
    chk({tag, ".op"},    {26'd0, opcode},     32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1'b1;

    // Back-to-back zero-wait fetch from reset
    step("idle",  0, 0, 0, 0,            1, 32'h0,   0, 32'h0,         32'h0);
    step("f0",    1, 0, 0, 0,            1, 32'h4,   1, 32'h20,        32'h4);
    step("f4",    1, 0, 0, 0,            1, 32'h8,   1, 32'h24,        32'h8);

    // Stall 3 cycles while word at 0x8 returns
    step("st0",   1, 1, 0, 0,            0, 32'hC,   1, 32'h24,        32'h8);
    step("st1",   0, 1, 0, 0,            0, 32'hC,   1, 32'h24,        32'h8);
    step("st2",   0, 1, 0, 0,            0, 32'hC,   1, 32'h24,        32'h8);
    step("unst",  0, 0, 0, 0,            1, 32'hC,   1, 32'h8C010004,  32'hC);

    // No-ack with and without stall
    step("nak_s", 0, 1, 0, 0,            1, 32'hC,   1, 32'h8C010004,  32'hC);
    step("bub",   0, 0, 0, 0,            1, 32'hC,   0, 32'h8C010004,  32'hC);
    step("fC",    1, 0, 0, 0,            1, 32'h10,  1, 32'h2C,        32'h10);

    // Branch while request to 0x10 outstanding, ack two cycles later
    step("dr0",   0, 0, 1, 32'h100,      1, 32'h10,  0, 32'h0,         32'h10);
    step("dr1",   0, 0, 0, 0,            1, 32'h10,  0, 32'h0,         32'h10);
    step("dr2",   1, 0, 0, 0,            1, 32'h100, 0, 32'h0,         32'h10);
    step("f100",  1, 0, 0, 0,            1, 32'h104, 1, 32'h120,       32'h104);

    // Branch together with stall while in HOLD, misaligned target
    step("hd0",   1, 1, 0, 0,            0, 32'h108, 1, 32'h120,       32'h104);
    step("hdbr",  0, 1, 1, 32'h203,      1, 32'h200, 0, 32'h0,         32'h104);
    step("f200",  1, 0, 0, 0,            1, 32'h204, 1, 32'h220,       32'h204);

    // Branch with ack same cycle, then wrap at top of address space
    step("bak",   1, 0, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h0,    32'h204);
    step("wrap",  1, 0, 0, 0,            1, 32'h0,   1, 32'h1C,        32'h0);
    step("f0b",   1, 0, 0, 0,            1, 32'h4,   1, 32'h20,        32'h4);

    // Repeated branch in DROP overwrites the latched target
    step("ow0",   0, 0, 1, 32'h300,      1, 32'h4,   0, 32'h0,         32'h4);
    step("ow1",   0, 0, 1, 32'h400,      1, 32'h4,   0, 32'h0,         32'h4);
    step("ow2",   1, 0, 0, 0,            1, 32'h400, 0, 32'h0,         32'h4);

    // Asynchronous reset while in DROP
    step("dr_r",  0, 0, 1, 32'h500,      1, 32'h400, 0, 32'h0,         32'h4);
    imem_ack = 1'b0; stall = 1'b0; br = 1'b0; br_tgt = '0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("arst");
    @(posedge clk);
    #1;
    chk_reset("arst_h");
    rst_n = 1'b1;
    step("idle2", 0, 0, 0, 0,            1, 32'h0,   0, 32'h0,         32'h0);
    step("f0c",   1, 0, 0, 0,            1, 32'h4,   1, 32'h20,        32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ifid.md
FETCH_IFID -- requirements
Module: fetch_ifid

Interface
REQ-001 CLK  input  1  single clock; all state updates on rising edge.
REQ-002 RST_N  input  1  asynchronous, active-low reset; asserting clears state immediately, release is synchronous to CLK.
REQ-003 IMEM_REQ  output  1  instruction-memory read request, registered.
REQ-004 IMEM_ADDR  output  32  byte address of the requested word; equals internal PC.
REQ-005 IMEM_ACK  input  1  memory returns IMEM_DATA this cycle; ignored when IMEM_REQ=0.
REQ-006 IMEM_DATA  input  32  fetched instruction word, valid only with IMEM_ACK.
REQ-007 STALL  input  1  hazard stall from decode; freezes IF/ID register.
REQ-008 BRANCH_TAKEN  input  1  redirect request; squashes the fetched-but-not-decoded instruction.
REQ-009 BRANCH_TARGET  input  32  redirect address; bits [1:0] forced to 0 internally.
REQ-010 IFID_VALID  output  1  IF/ID register holds a live instruction.
REQ-011 IFID_INSTR  output  32  IF/ID instruction word.
REQ-012 IFID_PC4  output  32  address of IFID_INSTR plus 4.
REQ-013 OPCODE  output  6  IFID_INSTR[31:26]; drives the control unit's 6-bit opcode input directly.

Function
REQ-014 FSM states: IDLE, FETCH, HOLD, DROP; encoding free.
REQ-015 IDLE: IMEM_REQ=0; unconditionally -> FETCH next cycle.
REQ-016 FETCH: IMEM_REQ=1; IMEM_ADDR stable until IMEM_ACK; no ACK -> remain.
REQ-017 FETCH, ACK, !STALL, !BRANCH_TAKEN: IFID_INSTR<=IMEM_DATA, IFID_PC4<=PC+4, IFID_VALID<=1, PC<=PC+4, remain FETCH (back-to-back, one instruction per cycle at zero-wait memory).
REQ-018 FETCH, ACK, STALL, !BRANCH_TAKEN: IMEM_DATA captured into internal skid buffer, IF/ID unchanged, PC<=PC+4, -> HOLD.
REQ-019 FETCH, no ACK, !STALL: IFID_VALID<=0 (bubble); no ACK with STALL: IF/ID unchanged.
REQ-020 HOLD: IMEM_REQ=0; while STALL, IF/ID and buffer unchanged; STALL low -> buffer loaded into IF/ID (VALID=1, PC4=buffered address+4), -> FETCH.
REQ-021 BRANCH_TAKEN has priority over STALL and ACK in every state: IFID_VALID<=0, IFID_INSTR<=0, skid buffer discarded.
REQ-022 BRANCH_TAKEN in FETCH with ACK same cycle: IMEM_DATA discarded, PC<=target, remain FETCH.
REQ-023 BRANCH_TAKEN in FETCH without ACK: IMEM_ADDR held (outstanding request not altered), target latched, -> DROP.
REQ-024 DROP: IMEM_REQ=1, address unchanged; on ACK data discarded, PC<=latched target, -> FETCH; a further BRANCH_TAKEN in DROP overwrites the latched target.
REQ-025 BRANCH_TAKEN in HOLD or IDLE: PC<=target, -> FETCH.
REQ-026 PC arithmetic modulo 2^32; 0xFFFFFFFC+4 wraps to 0x00000000, IFID_PC4 wraps identically.
REQ-027 IFID_VALID=0 qualifies all IF/ID outputs; OPCODE=0 with VALID=0 is a bubble, not an R-type instruction.
REQ-028 All outputs registered; no combinational path from any input to any output.

Reset
REQ-029 RST_N low: state=IDLE, PC=0, IMEM_REQ=0, IMEM_ADDR=0, IFID_VALID=0, IFID_INSTR=0, IFID_PC4=0, OPCODE=0, skid buffer and latched target cleared.
REQ-030 Reset mid-transaction abandons the outstanding request; first request after release is to address 0, issued the cycle after IDLE.

Verification
REQ-031 Reset release, zero-wait memory returning 0x00000020+addr: IMEM_REQ=1 at cycle 2, IFID_INSTR=0x00000020, OPCODE=0, PC4=4 at cycle 3, then 0x24/PC4=8 next cycle.
REQ-032 STALL held 3 cycles as ACK returns word at 0x8 (0x8C010004): IF/ID holds prior instruction, IMEM_REQ=0 in HOLD; after STALL drops IFID_INSTR=0x8C010004, OPCODE=0x23, PC4=0xC.
REQ-033 BRANCH_TAKEN target 0x100 while request to 0x10 outstanding, ACK 2 cycles later: IMEM_ADDR stays 0x10, IFID_VALID=0, returned data discarded, next IMEM_ADDR=0x100.
REQ-034 BRANCH_TAKEN and STALL together in HOLD, target 0x203: buffer discarded, IFID_VALID=0, next IMEM_ADDR=0x200.
REQ-035 BRANCH_TARGET 0xFFFFFFFC, two fetches: IFID_PC4=0x00000000, then IMEM_ADDR=0x00000000.
REQ-036 RST_N asserted during DROP: outputs at reset values asynchronously; after release fetch resumes at 0.
